byte_write_packer: RTL and testbench
====================================

BYTE_WRITE_PACKER -- requirements
Module: byte_write_packer

Interface
REQ-001 Parameter: TIMEOUT, default 4, number of consecutive cycles without in_valid after which a half-filled word is flushed (legal range 1..15).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream byte present.
REQ-005 in_ready  output  1  byte accepted when in_valid&&in_ready at clk edge.
REQ-006 in_data  input  8  byte value.
REQ-007 in_lane  input  1  target lane: 0 = d[7:0], 1 = d[15:8].
REQ-008 in_last  input  1  flush pending word immediately after this byte.
REQ-009 out_valid  output  1  write word present to byte-enabled register stage.
REQ-010 out_ready  input  1  downstream accepts word when out_valid&&out_ready.
REQ-011 out_d  output  16  write data; disabled lane driven 0.
REQ-012 out_byteena  output  2  lane enables, bit0 = low byte, bit1 = high byte.

Function
REQ-013 FSM states SHALL be IDLE, HOLD, EMIT; single pending register pend_d[15:0], pend_be[1:0] drives out_d/out_byteena directly.
REQ-014 IDLE: in_ready=1, out_valid=0; accepted lane0 byte -> pend_d[7:0]=in_data, pend_be=01, next HOLD (EMIT if in_last).
REQ-015 IDLE: accepted lane1 byte -> pend_d[15:8]=in_data, pend_be=10, next EMIT (no coalescing high-then-low).
REQ-016 HOLD: in_ready = !in_valid || in_lane (ready may depend on valid/lane combinationally).
REQ-017 HOLD: accepted lane1 byte -> merge into pend_d[15:8], pend_be=11, next EMIT.
REQ-018 HOLD: in_valid with lane0 -> byte not accepted, next EMIT with pend_be=01; byte re-accepted from IDLE later.
REQ-019 HOLD: idle counter cleared on entry, increments each cycle in_valid=0, clears when in_valid=1; counter==TIMEOUT-1 with in_valid=0 -> next EMIT.
REQ-020 EMIT: out_valid=1, in_ready=0; out_d/out_byteena stable until handshake; on out_ready -> pend cleared to 0, next IDLE.
REQ-021 Latency: accepted byte completing a word produces out_valid on the next cycle.
REQ-022 out_byteena SHALL never be 00 while out_valid=1; out_valid never asserts in IDLE or HOLD.
REQ-023 Throughput: max one word per two cycles (EMIT->IDLE turnaround); no bytes dropped or duplicated.

Reset
REQ-024 resetn=0 at clk edge SHALL force state IDLE, pend_d=0, pend_be=00, counter=0; outputs out_valid=0, out_d=0, out_byteena=00; in_ready=1 the cycle after release.
REQ-025 Reset mid-HOLD or mid-EMIT SHALL discard the pending word without emitting it; resetn dominates all other inputs.

Structure
REQ-026 Shared package byte_pack_pkg SHALL hold the state enum, lane constants (LANE_LO, LANE_HI) and byteena codes (BE_NONE, BE_LO, BE_HI, BE_ALL).
REQ-027 No sub-module; FSM, pending register and idle counter in one module, counter width 4 bits.

Verification
REQ-028 Bytes 0x34 lane0 then 0x12 lane1 back-to-back, out_ready=1 -> one word out_d=0x1234, out_byteena=11, one cycle after second accept.
REQ-029 Byte 0xAB lane1 from IDLE -> out_d=0xAB00, out_byteena=10 next cycle.
REQ-030 Byte 0x55 lane0 then in_valid=0 for TIMEOUT=4 cycles -> out_d=0x0055, out_byteena=01 after 4th idle cycle.
REQ-031 0x11 lane0 then 0x22 lane0 -> first word 0x0011/01, in_ready=0 during EMIT, second byte accepted from IDLE, later word 0x0022/01.
REQ-032 Word 0x1234/11 with out_ready=0 for 5 cycles -> out_valid, out_d, out_byteena held stable, in_ready=0; released on out_ready=1.
REQ-033 resetn=0 during HOLD with 0x77 pending -> no word emitted, all outputs 0, next accepted 0x88 lane1 emits 0x8800/10.

Source files
------------

// File: rtl/byte_pack_pkg.sv
// Shared types and constants for the byte-to-halfword write packer.
package byte_pack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        EMIT = 2'd2
    } state_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_ALL  = 2'b11;

endpackage

// File: rtl/byte_write_packer.sv
// Coalesces a low-lane byte and a following high-lane byte into one byte-enabled
// 16-bit write; a lone byte is flushed on in_last, a lane conflict, or an idle timeout.
module byte_write_packer
    import byte_pack_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_lane,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_d,
    output logic [1:0]  out_byteena
);

    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    state_e      state;
    logic [15:0] pend_d;
    logic [1:0]  pend_be;
    logic [3:0]  idle_cnt;

    // HOLD only takes a high-lane byte; a low-lane byte must wait for a fresh word.
    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = !in_valid || (in_lane == LANE_HI);
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid   = (state == EMIT);
    assign out_d       = pend_d;
    assign out_byteena = pend_be;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            pend_d   <= '0;
            pend_be  <= BE_NONE;
            idle_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (in_valid) begin
                        if (in_lane == LANE_HI) begin
                            pend_d  <= {in_data, 8'h00};
                            pend_be <= BE_HI;
                            state   <= EMIT;
                        end else begin
                            pend_d  <= {8'h00, in_data};
                            pend_be <= BE_LO;
                            state   <= in_last ? EMIT : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (in_valid) begin
                        idle_cnt <= '0;
                        if (in_lane == LANE_HI) begin
                            pend_d[15:8] <= in_data;
                            pend_be      <= BE_ALL;
                        end
                        state <= EMIT;
                    end else if (idle_cnt == TO_LAST) begin
                        idle_cnt <= '0;
                        state    <= EMIT;
                    end else begin
                        idle_cnt <= idle_cnt + 4'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pend_d  <= '0;
                        pend_be <= BE_NONE;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_write_packer.sv
// Bench for byte_write_packer: table-driven byte streams scored against a packing model,
// plus cycle-exact sequences for latency, timeout, backpressure and reset corners.
module tb_byte_write_packer;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_lane;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_d;
    logic [1:0]  out_byteena;

    byte_write_packer #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_lane     (in_lane),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_d       (out_d),
        .out_byteena (out_byteena)
    );

    typedef struct {
        logic [15:0] d;
        logic [1:0]  be;
    } word_t;

    typedef struct {
        logic [7:0] data;
        logic       lane;
        logic       last;
        int         gap;
    } vec_t;

    word_t      exp_q[$];
    vec_t       vecs[13];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic       have_lo = 1'b0;
    logic [7:0] lo_byte = 8'h00;
    logic       rand_bp = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] be);
        word_t w;
        w.d  = d;
        w.be = be;
        exp_q.push_back(w);
    endtask

    // Reference packing semantics: low byte waits for a high byte, anything else flushes.
    task automatic model_byte(input logic [7:0] d, input logic lane, input logic last);
        if (lane) begin
            if (have_lo) push({d, lo_byte}, 2'b11);
            else push({d, 8'h00}, 2'b10);
            have_lo = 1'b0;
        end else begin
            if (have_lo) push({8'h00, lo_byte}, 2'b01);
            lo_byte = d;
            have_lo = 1'b1;
            if (last) begin
                push({8'h00, d}, 2'b01);
                have_lo = 1'b0;
            end
        end
    endtask

    task automatic model_gap(input int n);
        if (have_lo && n >= TIMEOUT) begin
            push({8'h00, lo_byte}, 2'b01);
            have_lo = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] d, input logic lane, input logic last);
        logic acc;
        model_byte(d, lane, last);
        in_valid = 1'b1;
        in_data  = d;
        in_lane  = lane;
        in_last  = last;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            if (c == 59) check("accept_timeout", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        model_gap(n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        have_lo = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_d"}, 32'(out_d), 32'd0);
        check({tag, "_out_be"}, 32'(out_byteena), 32'd0);
    endtask

    // Scoreboard: every handshaked word must be the oldest expected one.
    always @(negedge clk) begin
        if (resetn === 1'b1 && out_valid === 1'b1) begin
            check("be_nonzero", 32'(out_byteena != 2'b00), 32'd1);
            check("ready_in_emit", 32'(in_ready), 32'd0);
            if (out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_word: got d=%h be=%b expected none", out_d,
                             out_byteena);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("word", {14'h0, out_byteena, out_d}, {14'h0, w.be, w.d});
                end
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_lane   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        vecs[0]  = '{8'h34, 1'b0, 1'b0, 0};
        vecs[1]  = '{8'h12, 1'b1, 1'b0, 0};
        vecs[2]  = '{8'hAB, 1'b1, 1'b0, 0};
        vecs[3]  = '{8'h55, 1'b0, 1'b0, 4};
        vecs[4]  = '{8'h11, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'h22, 1'b0, 1'b0, 1};
        vecs[6]  = '{8'h33, 1'b1, 1'b0, 0};
        vecs[7]  = '{8'h44, 1'b0, 1'b1, 2};
        vecs[8]  = '{8'h66, 1'b0, 1'b0, 3};
        vecs[9]  = '{8'h77, 1'b1, 1'b0, 0};
        vecs[10] = '{8'h88, 1'b0, 1'b0, 5};
        vecs[11] = '{8'h99, 1'b1, 1'b1, 0};
        vecs[12] = '{8'hC3, 1'b0, 1'b0, 0};

        do_reset();
        do_reset();
        check_zero_outputs("reset");
        resetn = 1'b1;
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Low then high back-to-back: merged word one cycle after the second accept.
        send(8'h34, 1'b0, 1'b0);
        send(8'h12, 1'b1, 1'b0);
        check("merge_valid", 32'(out_valid), 32'd1);
        check("merge_word", {14'h0, out_byteena, out_d}, {14'h0, 2'b11, 16'h1234});
        check("merge_in_ready", 32'(in_ready), 32'd0);
        tick();

        // Lone high byte from IDLE goes straight out.
        send(8'hAB, 1'b1, 1'b0);
        check("hi_only_word", {14'h0, out_byteena, out_d}, {14'h0, 2'b10, 16'hAB00});
        tick();

        // Timeout flush happens exactly after the TIMEOUT-th idle cycle.
        send(8'h55, 1'b0, 1'b0);
        model_gap(TIMEOUT);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (i < TIMEOUT) check("timeout_early", 32'(out_valid), 32'd0);
        end
        check("timeout_valid", 32'(out_valid), 32'd1);
        check("timeout_word", {14'h0, out_byteena, out_d}, {14'h0, 2'b01, 16'h0055});
        tick();

        // Backpressure: word and ready held stable until out_ready returns.
        out_ready = 1'b0;
        send(8'h34, 1'b0, 1'b0);
        send(8'h12, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_word", {14'h0, out_byteena, out_d}, {14'h0, 2'b11, 16'h1234});
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Two low bytes: the second is refused in HOLD and accepted later from IDLE.
        send(8'h11, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h22;
        in_lane  = 1'b0;
        #1;
        check("lane_conflict_ready", 32'(in_ready), 32'd0);
        send(8'h22, 1'b0, 1'b0);
        idle(TIMEOUT);
        idle(2);

        // Reset mid-HOLD discards the pending byte.
        send(8'h77, 1'b0, 1'b0);
        do_reset();
        check_zero_outputs("rst_hold");
        resetn = 1'b1;
        tick();
        check("rst_hold_in_ready", 32'(in_ready), 32'd1);
        idle(TIMEOUT + 2);
        check("rst_hold_no_word", 32'(out_valid), 32'd0);
        send(8'h88, 1'b1, 1'b0);
        check("rst_hold_next_word", {14'h0, out_byteena, out_d}, {14'h0, 2'b10, 16'h8800});
        tick();

        // Reset mid-EMIT discards a stalled word.
        out_ready = 1'b0;
        send(8'hAB, 1'b1, 1'b0);
        do_reset();
        check_zero_outputs("rst_emit");
        out_ready = 1'b1;
        resetn    = 1'b1;
        tick();
        idle(3);

        for (int pass = 0; pass < 2; pass++) begin
            rand_bp = (pass == 1);
            for (int i = 0; i < 13; i++) begin
                send(vecs[i].data, vecs[i].lane, vecs[i].last);
                if (vecs[i].gap > 0) idle(vecs[i].gap);
            end
            idle(TIMEOUT + 1);
            rand_bp   = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
            check("drain_empty", 32'(exp_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
